onchip_ram_avmm_slave: RTL and testbench

//  Parametrised on-chip RAM with an Avalon-MM slave interface; successor to the fixed 32-bit single-port Nios memory.

---
 rtl/onchip_ram_avmm_slave.sv | 140 ++++++++++++++
 tb/tb_onchip_ram_avmm_slave.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_ram_avmm_slave.sv
// On-chip RAM behind an Avalon-MM slave port with pipelined reads and an optional clear-on-reset sweep.
// Define ONCHIP_RAM_PARITY_EN to store per-byte even parity and add the parity_err output.
module onchip_ram_avmm_slave #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 13,
  parameter int unsigned DEPTH          = 6500,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    chipselect,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic                    clken,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest,
`ifdef ONCHIP_RAM_PARITY_EN
  output logic                    parity_err,
`endif
  output logic                    init_done
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef ONCHIP_RAM_PARITY_EN
  localparam int unsigned MEM_W = DATA_WIDTH + NB;
`else
  localparam int unsigned MEM_W = DATA_WIDTH;
`endif
  localparam bit LAT2 = (READ_LATENCY == 2);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t                state;
  logic [IDX_W-1:0]      clr_addr;
  logic                  init_q;
  logic [MEM_W-1:0]      mem [DEPTH];
  logic                  in_range_c;
  logic                  wr_acc_c;
  logic                  rd_acc_c;
  logic                  clr_c;
  logic [IDX_W-1:0]      idx_c;
  logic [DATA_WIDTH-1:0] rd_data_c;
  logic                  v1, v2;
  logic [DATA_WIDTH-1:0] d1, d2;
`ifdef ONCHIP_RAM_PARITY_EN
  logic                  rd_perr_c;
  logic                  e1, e2;
`endif

  // Requests are only accepted in RUN with the clock enabled.
  assign waitrequest = (state != RUN) | ~clken;
  assign in_range_c  = {1'b0, address} < (ADDR_WIDTH+1)'(DEPTH);
  assign idx_c       = IDX_W'(address);
  assign wr_acc_c    = chipselect & write & ~waitrequest;
  assign rd_acc_c    = chipselect & read & ~write & ~waitrequest;
  assign clr_c       = (state == INIT) && (CLEAR_ON_RESET != 0) && clken;

  // Out-of-range reads return zero and never flag a parity error.
  always_comb begin
    rd_data_c = '0;
`ifdef ONCHIP_RAM_PARITY_EN
    rd_perr_c = 1'b0;
`endif
    if (in_range_c) begin
      rd_data_c = mem[idx_c][DATA_WIDTH-1:0];
`ifdef ONCHIP_RAM_PARITY_EN
      for (int unsigned k = 0; k < NB; k++) begin
        rd_perr_c = rd_perr_c | ((^mem[idx_c][8*k +: 8]) ^ mem[idx_c][DATA_WIDTH+k]);
      end
`endif
    end
  end

  // Storage array: clear sweep during INIT, byte-masked writes during RUN.
  always_ff @(posedge clk) begin
    if (clr_c) begin
      mem[clr_addr] <= '0;
    end else if (wr_acc_c && in_range_c) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (byteenable[k]) begin
          mem[idx_c][8*k +: 8] <= writedata[8*k +: 8];
`ifdef ONCHIP_RAM_PARITY_EN
          mem[idx_c][DATA_WIDTH+k] <= ^writedata[8*k +: 8];
`endif
        end
      end
    end
  end

  // INIT/RUN sequencer and read pipeline; everything holds while clken is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= INIT;
      clr_addr <= '0;
      init_q   <= 1'b0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      d1       <= '0;
      d2       <= '0;
`ifdef ONCHIP_RAM_PARITY_EN
      e1       <= 1'b0;
      e2       <= 1'b0;
`endif
    end else if (clken) begin
      case (state)
        INIT: begin
          if ((CLEAR_ON_RESET == 0) || (clr_addr == IDX_W'(DEPTH - 1))) begin
            state  <= RUN;
            init_q <= 1'b1;
          end else begin
            clr_addr <= clr_addr + IDX_W'(1);
          end
        end
        default: state <= RUN;
      endcase
      v1 <= rd_acc_c;
      v2 <= v1;
      if (rd_acc_c) d1 <= rd_data_c;
      if (v1)       d2 <= d1;
`ifdef ONCHIP_RAM_PARITY_EN
      e1 <= rd_acc_c & rd_perr_c;
      e2 <= e1;
`endif
    end
  end

  assign readdata      = LAT2 ? d2 : d1;
  assign readdatavalid = (LAT2 ? v2 : v1) & clken;
  assign init_done     = (CLEAR_ON_RESET != 0) ? init_q : 1'b1;
`ifdef ONCHIP_RAM_PARITY_EN
  assign parity_err    = (LAT2 ? e2 : e1) & clken;
`endif

endmodule

// File: tb/tb_onchip_ram_avmm_slave.sv
// Randomised and directed bench for onchip_ram_avmm_slave against a transaction-level model.
module tb_onchip_ram_avmm_slave;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LAT = 2;
  localparam int unsigned NB = DW / 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          chipselect = 1'b0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic          clken = 1'b1;
  logic [AW-1:0] address = '0;
  logic [NB-1:0] byteenable = '0;
  logic [DW-1:0] writedata = '0;
  logic [DW-1:0] readdata;
  logic          readdatavalid;
  logic          waitrequest;
  logic          init_done;
`ifdef ONCHIP_RAM_PARITY_EN
  logic          parity_err;
`endif

  int checks = 0;
  int errors = 0;
  int rdv_seen = 0;

  onchip_ram_avmm_slave #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(LAT), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
    .read(read), .write(write), .byteenable(byteenable), .writedata(writedata),
    .clken(clken), .readdata(readdata), .readdatavalid(readdatavalid),
    .waitrequest(waitrequest),
`ifdef ONCHIP_RAM_PARITY_EN
    .parity_err(parity_err),
`endif
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: memory image, count of enabled edges since reset, and reads due at a given edge count.
  typedef struct {
    logic [DW-1:0] data;
    bit            perr;
    int            due;
  } rd_t;

  rd_t           pend[$];
  logic [DW-1:0] mdl_mem [DEPTH];
  bit            corrupt [DEPTH];
  int            en_edges = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_edges = 0;
      pend.delete();
      for (int i = 0; i < int'(DEPTH); i++) begin
        mdl_mem[i] = '0;
        corrupt[i] = 1'b0;
      end
    end else if (clken) begin
      int a;
      rd_t r;
      a = int'(address);
      if (pend.size() > 0 && pend[0].due == en_edges) void'(pend.pop_front());
      if (en_edges >= int'(DEPTH) && chipselect && write) begin
        if (a < int'(DEPTH)) begin
          for (int k = 0; k < int'(NB); k++) begin
            if (byteenable[k]) begin
              mdl_mem[a][8*k +: 8] = writedata[8*k +: 8];
              if (k == 2) corrupt[a] = 1'b0;
            end
          end
        end
      end else if (en_edges >= int'(DEPTH) && chipselect && read) begin
        r.data = (a < int'(DEPTH)) ? mdl_mem[a] : '0;
        r.perr = (a < int'(DEPTH)) ? corrupt[a] : 1'b0;
        r.due  = en_edges + int'(LAT);
        pend.push_back(r);
      end
      en_edges++;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    bit run_m;
    bit exp_v;
    run_m = reset_n && (en_edges >= int'(DEPTH));
    exp_v = reset_n && clken && (pend.size() > 0) && (pend[0].due == en_edges);
    chk("waitrequest", 32'(waitrequest), 32'(!(run_m && clken)));
    chk("init_done", 32'(init_done), 32'(run_m));
    chk("readdatavalid", 32'(readdatavalid), 32'(exp_v));
    if (exp_v) chk("readdata", readdata, pend[0].data);
    if (!reset_n) chk("readdata_reset", readdata, 32'h0);
`ifdef ONCHIP_RAM_PARITY_EN
    chk("parity_err", 32'(parity_err), 32'(exp_v && pend[0].perr));
`endif
    if (readdatavalid === 1'b1) rdv_seen++;
  end

  // Tasks start at #1 after an edge and return at #1 after the accepting edge.
  task automatic do_write(input int a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    chipselect = 1'b1; write = 1'b1; read = 1'b0; clken = 1'b1;
    address = AW'(a); writedata = d; byteenable = be;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic do_read(input int a, output logic [DW-1:0] d);
    int lat;
    lat = -1;
    d = 32'hBAD0BAD0;
    chipselect = 1'b1; read = 1'b1; write = 1'b0; clken = 1'b1; address = AW'(a);
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (readdatavalid) begin
        d = readdata;
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
    chk("read_latency", 32'(lat), 32'(LAT));
  endtask

  task automatic count_init(input string name);
    int n;
    n = 0;
    while (waitrequest && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    chk(name, 32'(n), 32'(DEPTH));
    chk("init_done_set", 32'(init_done), 32'h1);
  endtask

  initial begin
    logic [DW-1:0] d;
    int base;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    count_init("init_cycles");
    for (int a = 0; a < int'(DEPTH); a++) begin
      do_read(a, d);
      chk("cleared_word", d, 32'h0);
    end

    do_write(5, 32'hDEADBEEF, 4'b1111);
    do_write(5, 32'h11223344, 4'b0101);
    do_read(5, d);
    chk("byte_merge", d, 32'hDE22BE44);
    do_write(7, 32'h0BADF00D, 4'b1111);
    do_read(7, d);
    chk("read_after_write", d, 32'h0BADF00D);
    do_write(7, 32'hFFFFFFFF, 4'b0000);
    do_read(7, d);
    chk("be_zero_write", d, 32'h0BADF00D);

    do_write(15, 32'h12345678, 4'b1111);
    do_write(16, 32'hFFFFFFFF, 4'b1111);
    do_write(20, 32'hFFFFFFFF, 4'b1111);
    do_read(16, d);
    chk("oor_read_16", d, 32'h0);
    do_read(20, d);
    chk("oor_read_20", d, 32'h0);
    do_read(15, d);
    chk("last_word_kept", d, 32'h12345678);

    do_write(1, 32'hA1A1A1A1, 4'b1111);
    do_write(2, 32'hA2A2A2A2, 4'b1111);
    do_write(3, 32'hA3A3A3A3, 4'b1111);
    base = rdv_seen;
    chipselect = 1'b1; read = 1'b1; address = AW'(1);
    @(posedge clk); #1 address = AW'(2);
    @(posedge clk); #1 address = AW'(3); clken = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 clken = 1'b1;
    @(posedge clk); #1 chipselect = 1'b0; read = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("stream_pulses", 32'(rdv_seen - base), 32'h3);

    for (int c = 0; c < 800; c++) begin
      clken      = ($urandom_range(0, 9) != 0);
      chipselect = ($urandom_range(0, 3) != 0);
      read       = 1'($urandom_range(0, 1));
      write      = 1'($urandom_range(0, 1));
      address    = AW'($urandom_range(0, 19));
      byteenable = NB'($urandom_range(0, 15));
      writedata  = $urandom();
      @(posedge clk); #1;
    end
    clken = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    repeat (4) begin @(posedge clk); #1; end

    chipselect = 1'b1; read = 1'b1; address = AW'(5);
    @(posedge clk); #1 reset_n = 1'b0;
    chipselect = 1'b0; read = 1'b0;
    #1;
    chk("rst_rdv", 32'(readdatavalid), 32'h0);
    chk("rst_wait", 32'(waitrequest), 32'h1);
    chk("rst_init", 32'(init_done), 32'h0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (7) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("midinit_wait", 32'(waitrequest), 32'h1);
    chk("midinit_init", 32'(init_done), 32'h0);
    @(posedge clk); #1 reset_n = 1'b1;
    count_init("reinit_cycles");
    do_read(15, d);
    chk("recleared_word", d, 32'h0);

`ifdef ONCHIP_RAM_PARITY_EN
    do_write(3, 32'hCAFEF00D, 4'b1111);
    dut.mem[3][DW+2] = ~dut.mem[3][DW+2];
    corrupt[3] = 1'b1;
    do_read(3, d);
    do_read(4, d);
`endif

    repeat (4) begin @(posedge clk); #1; end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
